// File: rtl/n64_bus_router_pkg.sv
// Shared N64-side definitions: device IDs, device address windows and the
// router FSM state type. Slot index in the router equals the device ID here.
package sc64;

  localparam int N64_WINDOWS = 5;

  typedef enum logic [2:0] {
    ID_N64_SDRAM      = 3'd0,
    ID_N64_BOOTLOADER = 3'd1,
    ID_N64_FLASHRAM   = 3'd2,
    ID_N64_DDREGS     = 3'd3,
    ID_N64_CFG        = 3'd4
  } e_n64_id;

  // Window k matches when (address & mask[k]) == base[k]; windows never overlap.
  localparam logic [31:0] N64_WIN_BASE [N64_WINDOWS] = '{
    32'h1000_0000,  // SDRAM
    32'h1FC0_0000,  // bootloader
    32'h0800_0000,  // flashram
    32'h0500_0000,  // DD regs
    32'h1E00_0000   // cfg
  };

  localparam logic [31:0] N64_WIN_MASK [N64_WINDOWS] = '{
    32'hFC00_0000,
    32'hFFF0_0000,
    32'hFE00_0000,
    32'hFF00_0000,
    32'hFF00_0000
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } e_state;

  function automatic logic n64_window_match(input logic [31:0] address, input int id);
    return (address & N64_WIN_MASK[id]) == N64_WIN_BASE[id];
  endfunction

endpackage

// File: rtl/n64_bus_decode.sv
// Combinational address-to-slot decoder for the N64 device map. Also used by
// n64_pi for prefetch hints, so it stays free of any state.
module n64_bus_decode
  import sc64::*;
#(
  parameter int NUM_DEVICES = 5,
  parameter int SLOT_W      = 3
) (
  input  logic [31:0]       address,
  output logic              hit,
  output logic [SLOT_W-1:0] slot
);

  logic [NUM_DEVICES-1:0] match_s;

  // Match every window, then fold the (at most one-hot) match into a slot index.
  always_comb begin
    match_s = '0;
    hit     = 1'b0;
    slot    = '0;
    for (int k = 0; k < NUM_DEVICES; k++) begin
      match_s[k] = n64_window_match(address, k);
      hit        = hit | match_s[k];
      slot       = slot | ({SLOT_W{match_s[k]}} & SLOT_W'(k));
    end
  end

endmodule

// File: rtl/n64_bus_router.sv
// Routes PI master transactions to one N64 bus device and returns its data.
// Unmapped addresses complete with open-bus data (low address half), silent
// devices complete with 16'hFFFF after a bounded wait, so the PI never stalls.
// Optional macro N64_BUS_ROUTER_STATS_EN: enables the saturating forced-
// completion counter on timeout_count; without it timeout_count is tied to 0.
module n64_bus_router
  import sc64::*;
#(
  parameter int NUM_DEVICES    = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      m_request,
  input  logic                      m_write,
  input  logic [31:0]               m_address,
  input  logic [15:0]               m_wdata,
  output logic                      m_ack,
  output logic [15:0]               m_rdata,
  output logic [NUM_DEVICES-1:0]    d_request,
  output logic                      d_write,
  output logic [31:0]               d_address,
  output logic [15:0]               d_wdata,
  input  logic [NUM_DEVICES-1:0]    d_ack,
  input  logic [16*NUM_DEVICES-1:0] d_rdata,
  output logic [7:0]                timeout_count
);

  localparam int SLOT_W = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_DEVICES-1:0] ONE_HOT_0 = {{(NUM_DEVICES-1){1'b0}}, 1'b1};

  e_state                 state_r, state_nx_s;
  logic                   hit_s;
  logic [SLOT_W-1:0]      slot_s;
  logic [SLOT_W-1:0]      sel_r;
  logic                   hit_r;       // 0: current transaction is an open-bus miss
  logic [CNT_W-1:0]       wait_cnt_r;
  logic                   strobe_s;
  logic                   ack_sel_s;
  logic [15:0]            rdata_sel_s;
  logic                   timeout_s;
  logic                   accept_s;
  logic                   m_ack_s;
  logic [15:0]            m_rdata_s;
  logic [NUM_DEVICES-1:0] d_request_s;
  logic                   m_ack_r;
  logic [15:0]            m_rdata_r;
  logic [NUM_DEVICES-1:0] d_request_r;
  logic                   d_write_r;
  logic [31:0]            d_address_r;
  logic [15:0]            d_wdata_r;

  n64_bus_decode #(
    .NUM_DEVICES (NUM_DEVICES),
    .SLOT_W      (SLOT_W)
  ) u_decode (
    .address (m_address),
    .hit     (hit_s),
    .slot    (slot_s)
  );

  // The strobe cycle does not count as waiting: the device cannot have answered yet.
  assign strobe_s  = |d_request_r;
  assign timeout_s = hit_r & ~strobe_s & (wait_cnt_r == CNT_LAST);

  // Pick the selected device's ack and data; acks from other slots are ignored.
  always_comb begin
    ack_sel_s   = 1'b0;
    rdata_sel_s = 16'h0000;
    for (int k = 0; k < NUM_DEVICES; k++) begin
      ack_sel_s   = ack_sel_s | (d_ack[k] & (sel_r == SLOT_W'(k)));
      rdata_sel_s = rdata_sel_s | (d_rdata[16*k +: 16] & {16{sel_r == SLOT_W'(k)}});
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic; a miss spends one WAIT cycle before completing.
  always_comb begin
    state_nx_s = S_IDLE;
    case (state_r)
      S_IDLE: begin
        if (m_request) begin
          state_nx_s = S_WAIT;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!hit_r || ack_sel_s || timeout_s) begin
          state_nx_s = S_DONE;
        end else begin
          state_nx_s = S_WAIT;
        end
      end
      S_DONE:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered master/device strobes.
  always_comb begin
    accept_s    = 1'b0;
    d_request_s = '0;
    m_ack_s     = 1'b0;
    m_rdata_s   = 16'h0000;
    case (state_r)
      S_IDLE: begin
        if (m_request) begin
          accept_s = 1'b1;
          if (hit_s) begin
            d_request_s = ONE_HOT_0 << slot_s;
          end else begin
            d_request_s = '0;
          end
        end else begin
          accept_s = 1'b0;
        end
      end
      S_WAIT: begin
        if (!hit_r) begin
          m_ack_s   = 1'b1;
          m_rdata_s = d_address_r[15:0];
        end else if (ack_sel_s) begin
          m_ack_s   = 1'b1;
          m_rdata_s = rdata_sel_s;
        end else if (timeout_s) begin
          m_ack_s   = 1'b1;
          m_rdata_s = 16'hFFFF;
        end else begin
          m_ack_s   = 1'b0;
        end
      end
      default: begin
        m_ack_s = 1'b0;
      end
    endcase
  end

  // Output registers; reset abandons any transaction without an m_ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ack_r     <= 1'b0;
      m_rdata_r   <= 16'h0000;
      d_request_r <= '0;
    end else begin
      m_ack_r     <= m_ack_s;
      m_rdata_r   <= m_rdata_s;
      d_request_r <= d_request_s;
    end
  end

  // Transaction context: latched on accept, held until the next accepted request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_write_r   <= 1'b0;
      d_address_r <= 32'h0000_0000;
      d_wdata_r   <= 16'h0000;
      sel_r       <= '0;
      hit_r       <= 1'b0;
      wait_cnt_r  <= '0;
    end else if (accept_s) begin
      d_write_r   <= m_write;
      d_address_r <= m_address;
      d_wdata_r   <= m_wdata;
      sel_r       <= slot_s;
      hit_r       <= hit_s;
      wait_cnt_r  <= '0;
    end else if ((state_r == S_WAIT) && !strobe_s) begin
      wait_cnt_r  <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r  <= wait_cnt_r;
    end
  end

`ifdef N64_BUS_ROUTER_STATS_EN
  logic       timeout_hit_s;
  logic [7:0] timeout_count_r;

  // A forced completion only counts when no ack arrived in the same cycle.
  assign timeout_hit_s = (state_r == S_WAIT) & hit_r & ~ack_sel_s & timeout_s;

  // Saturating forced-completion counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_count_r <= 8'h00;
    end else if (timeout_hit_s && (timeout_count_r != 8'hFF)) begin
      timeout_count_r <= timeout_count_r + 8'h01;
    end else begin
      timeout_count_r <= timeout_count_r;
    end
  end

  assign timeout_count = timeout_count_r;
`else
  assign timeout_count = 8'h00;
`endif

  assign m_ack     = m_ack_r;
  assign m_rdata   = m_rdata_r;
  assign d_request = d_request_r;
  assign d_write   = d_write_r;
  assign d_address = d_address_r;
  assign d_wdata   = d_wdata_r;

endmodule

// File: tb/tb_n64_bus_router.sv
// Testbench for n64_bus_router: transaction-level reference model computing
// expected per-cycle outputs from the device map and latency rules.
module tb_n64_bus_router;

  localparam int ND = 5;
  localparam int T  = 64;
`ifdef N64_BUS_ROUTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // Device windows as inclusive address ranges.
  localparam logic [31:0] WIN_LO [ND] = '{32'h1000_0000, 32'h1FC0_0000, 32'h0800_0000,
                                          32'h0500_0000, 32'h1E00_0000};
  localparam logic [31:0] WIN_HI [ND] = '{32'h13FF_FFFF, 32'h1FCF_FFFF, 32'h09FF_FFFF,
                                          32'h05FF_FFFF, 32'h1EFF_FFFF};

  logic              clk = 1'b0;
  logic              reset_n;
  logic              m_request;
  logic              m_write;
  logic [31:0]       m_address;
  logic [15:0]       m_wdata;
  logic              m_ack;
  logic [15:0]       m_rdata;
  logic [ND-1:0]     d_request;
  logic              d_write;
  logic [31:0]       d_address;
  logic [15:0]       d_wdata;
  logic [ND-1:0]     d_ack;
  logic [16*ND-1:0]  d_rdata;
  logic [7:0]        timeout_count;

  // Expected outputs for the current cycle.
  logic              exp_ack;
  logic [15:0]       exp_rdata;
  logic [ND-1:0]     exp_dreq;
  logic              exp_dw;
  logic [31:0]       exp_da;
  logic [15:0]       exp_dd;
  logic [7:0]        exp_tc;

  int  vectors     = 0;
  int  miscompares = 0;
  int  cyc         = 0;
  bit  chk_en      = 1'b0;

  n64_bus_router #(
    .NUM_DEVICES    (ND),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .m_request     (m_request),
    .m_write       (m_write),
    .m_address     (m_address),
    .m_wdata       (m_wdata),
    .m_ack         (m_ack),
    .m_rdata       (m_rdata),
    .d_request     (d_request),
    .d_write       (d_write),
    .d_address     (d_address),
    .d_wdata       (d_wdata),
    .d_ack         (d_ack),
    .d_rdata       (d_rdata),
    .timeout_count (timeout_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic int model_slot(input logic [31:0] a);
    int s;
    s = -1;
    for (int k = 0; k < ND; k++) begin
      if (a >= WIN_LO[k] && a <= WIN_HI[k]) s = k;
    end
    return s;
  endfunction

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_ack",         32'(m_ack),         32'(exp_ack));
      check("m_rdata",       32'(m_rdata),       32'(exp_rdata));
      check("d_request",     32'(d_request),     32'(exp_dreq));
      check("d_write",       32'(d_write),       32'(exp_dw));
      check("d_address",     d_address,          exp_da);
      check("d_wdata",       32'(d_wdata),       32'(exp_dd));
      check("timeout_count", 32'(timeout_count), 32'(exp_tc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    m_request = 1'b0;
    m_write   = 1'($urandom);
    m_address = $urandom;
    m_wdata   = 16'($urandom);
    d_ack     = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    exp_ack = 1'b0; exp_rdata = 16'h0000; exp_dreq = '0;
    exp_dw = 1'b0; exp_da = 32'h0; exp_dd = 16'h0000; exp_tc = 8'h00;
    #1;
    check("rst_m_ack",     32'(m_ack),         32'h0);
    check("rst_m_rdata",   32'(m_rdata),       32'h0);
    check("rst_d_request", 32'(d_request),     32'h0);
    check("rst_d_address", d_address,          32'h0);
    check("rst_timeout",   32'(timeout_count), 32'h0);
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  // One master transaction. dly: device acks dly cycles after its strobe
  // cycle (<1 or >T means it never answers in time). sdata>=0 fixes the
  // selected device's data. noise: 0 none, 1 random foreign acks,
  // 2 single slot-0 ack pulse two cycles after the request.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [15:0] wd,
                         input int dly, input int sdata, input int noise, input int abort_at,
                         output int ack_off, output logic [15:0] rd);
    int n, slot, ack_c, ack_in;
    bit tmo;
    logic [ND-1:0] mask;
    n      = cyc;
    slot   = model_slot(addr);
    tmo    = 1'b0;
    ack_in = -1;
    for (int k = 0; k < ND; k++) d_rdata[16*k +: 16] = 16'($urandom);
    if (slot >= 0 && sdata >= 0) d_rdata[16*slot +: 16] = 16'(sdata);
    if (slot < 0) begin
      ack_c = n + 2;
      rd    = addr[15:0];
    end else if (dly >= 1 && dly <= T) begin
      ack_in = n + 1 + dly;
      ack_c  = ack_in + 1;
      rd     = d_rdata[16*slot +: 16];
    end else begin
      ack_c = n + 2 + T;
      rd    = 16'hFFFF;
      tmo   = 1'b1;
    end
    ack_off = ack_c - n;
    mask = '1;
    if (slot >= 0) mask[slot] = 1'b0;
    for (int c = n; c <= ack_c; c++) begin
      if (c == n) begin
        m_request = 1'b1; m_write = wr; m_address = addr; m_wdata = wd;
      end else begin
        m_request = 1'b0; m_write = 1'($urandom); m_address = $urandom; m_wdata = 16'($urandom);
      end
      d_ack = '0;
      if (noise == 1) d_ack = ND'($urandom) & mask;
      else if (noise == 2 && c == n + 2) d_ack = ND'(1) & mask;
      if (c == ack_in) d_ack[slot] = 1'b1;
      exp_dreq = (c == n + 1 && slot >= 0) ? (ND'(1) << slot) : '0;
      if (c == n + 1) begin
        exp_dw = wr; exp_da = addr; exp_dd = wd;
      end
      exp_ack   = (c == ack_c);
      exp_rdata = (c == ack_c) ? rd : 16'h0000;
      if (c == ack_c && tmo && STATS && exp_tc != 8'hFF) exp_tc = exp_tc + 8'h01;
      if (abort_at >= 0 && c == n + abort_at) begin
        do_reset();
        return;
      end
      step();
    end
    idle_inputs();
    exp_ack = 1'b0; exp_rdata = 16'h0000; exp_dreq = '0;
  endtask

  initial begin
    int off;
    logic [15:0] rd;
    int k, dly;
    logic [31:0] a;
    reset_n = 1'b1;
    idle_inputs();
    d_rdata = '0;
    #2;
    chk_en = 1'b1;
    do_reset();

    // Model pins: address map.
    check("map_sdram", 32'(model_slot(32'h1000_0002)), 32'd0);
    check("map_boot",  32'(model_slot(32'h1FC0_0000)), 32'd1);
    check("map_flash", 32'(model_slot(32'h0800_0000)), 32'd2);
    check("map_cfg",   32'(model_slot(32'h1E00_0010)), 32'd4);
    check("map_miss",  32'(model_slot(32'h0400_1236)), 32'hFFFF_FFFF);

    run_txn(1'b0, 32'h1000_0002, 16'h0000, 1, 16'hABCD, 0, -1, off, rd);
    check("sdram_lat", 32'(off), 32'd3);
    check("sdram_rd",  32'(rd),  32'h0000_ABCD);

    run_txn(1'b1, 32'h1E00_0010, 16'h1234, 1, -1, 0, -1, off, rd);
    check("cfg_wr_lat", 32'(off), 32'd3);

    run_txn(1'b0, 32'h0400_1236, 16'h0000, 1, -1, 1, -1, off, rd);
    check("miss_lat", 32'(off), 32'd2);
    check("miss_rd",  32'(rd),  32'h0000_1236);

    run_txn(1'b0, 32'h0800_0000, 16'h0000, -1, -1, 0, -1, off, rd);
    check("tmo_lat",   32'(off), 32'(T + 2));
    check("tmo_rd",    32'(rd),  32'h0000_FFFF);
    check("tmo_count", 32'(timeout_count), STATS ? 32'd1 : 32'd0);

    // Ack in the very cycle the wait expires: ack wins.
    run_txn(1'b0, 32'h0800_0100, 16'h0000, T, 16'h5A5A, 0, -1, off, rd);
    check("edge_lat", 32'(off), 32'(T + 2));
    check("edge_rd",  32'(rd),  32'h0000_5A5A);
    run_txn(1'b0, 32'h0800_0200, 16'h0000, T + 1, -1, 0, -1, off, rd);
    check("late_rd",  32'(rd),  32'h0000_FFFF);

    run_txn(1'b0, 32'h1FC0_0000, 16'h0000, 4, 16'h0BB1, 2, -1, off, rd);
    check("boot_lat", 32'(off), 32'd6);

    run_txn(1'b0, 32'h0800_0000, 16'h0000, -1, -1, 0, 5, off, rd);
    run_txn(1'b0, 32'h1000_0040, 16'h0000, 2, 16'hC0DE, 0, -1, off, rd);
    check("post_rst_lat", 32'(off), 32'd4);

    for (int i = 0; i < 200; i++) begin
      k = int'($urandom_range(0, ND));
      if (k == ND) a = $urandom;
      else a = WIN_LO[k] + ($urandom % (WIN_HI[k] - WIN_LO[k] + 32'd1));
      dly = ($urandom_range(0, 9) == 0) ? int'($urandom_range(T - 1, T + 1))
                                        : int'($urandom_range(1, 8));
      run_txn(1'($urandom), a, 16'($urandom), dly, -1, int'($urandom_range(0, 1)), -1, off, rd);
      repeat ($urandom_range(0, 2)) step();
    end

    for (int i = 0; i < 300; i++) begin
      a = WIN_LO[2] + ($urandom % 32'h0200_0000);
      run_txn(1'($urandom), a, 16'($urandom), -1, -1, 1, -1, off, rd);
    end
    check("tmo_saturate", 32'(timeout_count), STATS ? 32'd255 : 32'd0);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
